// File: rtl/instruction_fetch_phase.sv
// Instruction fetch stage: owns the PC, runs the req/ready handshake to
// instruction memory, keeps one skid entry for fetches that finish under a
// stall, and drives the IF/ID bundle consumed by decode.
module instruction_fetch_phase #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpRegister,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JumpRegTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    StFetch    = 2'd0,
    StBuffered = 2'd1,
    StDrop     = 2'd2
  } state_e;

  state_e      state;
  logic [31:0] fetch_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic [31:0] pend_target;

  logic        complete;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] fetch_pc4;

  assign imem_addr = fetch_pc;
  assign fetch_pc4 = fetch_pc + 32'd4;

  // Handshake completion, redirect qualification and target priority
  always_comb begin
    complete = imem_req & imem_ready;
    redirect = valid_out & ~Stall & (Branch | Jump | JumpRegister);
    if (JumpRegister) begin
      target = JumpRegTarget;
    end else if (Jump) begin
      target = JumpTarget;
    end else begin
      target = BranchTarget;
    end
  end

  // Fetch FSM: PC, request, skid and IF/ID registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= StFetch;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc4    <= 32'h0;
      pend_target <= 32'h0;
      instr_out   <= 32'h0;
      pc_out      <= 32'h0;
      valid_out   <= 1'b0;
    end else begin
      unique case (state)
        StFetch: begin
          if (redirect) begin
            valid_out  <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
            // An unfinished request cannot be withdrawn; wait it out in DROP.
            if (complete || !imem_req) begin
              fetch_pc <= target;
              imem_req <= 1'b1;
            end else begin
              pend_target <= target;
              state       <= StDrop;
            end
          end else if (Stall) begin
            if (complete) begin
              skid_instr <= imem_rdata;
              skid_pc4   <= fetch_pc4;
              fetch_pc   <= fetch_pc4;
              imem_req   <= 1'b0;
              state      <= StBuffered;
            end else begin
              imem_req <= 1'b1;
            end
          end else begin
            imem_req <= 1'b1;
            if (complete) begin
              instr_out <= imem_rdata;
              pc_out    <= fetch_pc4;
              valid_out <= 1'b1;
              fetch_pc  <= fetch_pc4;
            end else begin
              valid_out <= 1'b0;
            end
          end
        end
        StBuffered: begin
          if (redirect) begin
            valid_out  <= 1'b0;
            skid_instr <= 32'h0;
            skid_pc4   <= 32'h0;
            fetch_pc   <= target;
            imem_req   <= 1'b1;
            state      <= StFetch;
          end else if (!Stall) begin
            instr_out <= skid_instr;
            pc_out    <= skid_pc4;
            valid_out <= 1'b1;
            imem_req  <= 1'b1;
            state     <= StFetch;
          end
        end
        StDrop: begin
          // Returning word belongs to the flushed path and is discarded.
          if (complete) begin
            fetch_pc <= pend_target;
            state    <= StFetch;
          end
        end
        default: begin
          state    <= StFetch;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Directed bench for instruction_fetch_phase. Memory returns the address as
// the instruction word, so expected IF/ID contents follow directly from PCs.
module tb_instruction_fetch_phase;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Branch;
  logic        Jump;
  logic        JumpRegister;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic [31:0] JumpRegTarget;
  logic        imem_ready;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  assign imem_rdata = imem_addr;
  assign w_rdata    = w_addr;

  instruction_fetch_phase #(.RESET_PC(32'h0000_0000)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch       (Branch),
    .Jump         (Jump),
    .JumpRegister (JumpRegister),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .JumpRegTarget(JumpRegTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out)
  );

  instruction_fetch_phase #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch       (Branch),
    .Jump         (Jump),
    .JumpRegister (JumpRegister),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .JumpRegTarget(JumpRegTarget),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (w_rdata),
    .instr_out    (w_instr),
    .pc_out       (w_pc),
    .valid_out    (w_valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset both DUTs with idle inputs; returns just after release, mid-cycle.
  task automatic do_reset();
    Reset         = 1'b0;
    Stall         = 1'b0;
    Branch        = 1'b0;
    Jump          = 1'b0;
    JumpRegister  = 1'b0;
    BranchTarget  = 32'h0;
    JumpTarget    = 32'h0;
    JumpRegTarget = 32'h0;
    imem_ready    = 1'b1;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Stall = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; JumpRegTarget = 32'h0;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (instr_out !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h want %h", instr_out, 32'h0);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_held: got %b want 0", imem_req);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick();
    checks++;
    if (imem_req !== 1'b1 || valid_out !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stream_first_req: got req=%b valid=%b addr=%h want req=1 valid=0 addr=0",
               imem_req, valid_out, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (instr_out !== 32'(4 * k) || pc_out !== 32'(4 * k + 4) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got instr=%h pc=%h valid=%b want instr=%h pc=%h valid=1",
                 k, instr_out, pc_out, valid_out, 32'(4 * k), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    tick();
    tick();
    tick();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || imem_addr !== 32'h8 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL wait_%0d: got valid=%b addr=%h req=%b want valid=0 addr=8 req=1",
                 k, valid_out, imem_addr, imem_req);
      end
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (instr_out !== 32'h8 || pc_out !== 32'hC || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: got instr=%h pc=%h valid=%b want instr=8 pc=c valid=1",
               instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick();
    tick();
    Stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (instr_out !== 32'h0 || pc_out !== 32'h4 || valid_out !== 1'b1 ||
          imem_req !== 1'b0 || imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL stall_hold_%0d: got instr=%h pc=%h valid=%b req=%b addr=%h want 0/4/1/0/8",
                 k, instr_out, pc_out, valid_out, imem_req, imem_addr);
      end
    end
    Stall = 1'b0;
    tick();
    checks++;
    if (instr_out !== 32'h4 || pc_out !== 32'h8 || valid_out !== 1'b1 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got instr=%h pc=%h valid=%b req=%b want 4/8/1/1",
               instr_out, pc_out, valid_out, imem_req);
    end
    tick();
    checks++;
    if (instr_out !== 32'h8 || pc_out !== 32'hC || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_next: got instr=%h pc=%h valid=%b want 8/c/1",
               instr_out, pc_out, valid_out);
    end
  endtask

  // Reaches the state with instr 0x10 valid in IF/ID and fetch_pc at 0x14.
  task automatic run_to_0x10();
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (instr_out !== 32'h10 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL reach_0x10: got instr=%h valid=%b want 10/1", instr_out, valid_out);
    end
  endtask

  task automatic test_branch();
    run_to_0x10();
    Branch       = 1'b1;
    BranchTarget = 32'h100;
    tick();
    Branch = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL branch_bubble: got valid=%b addr=%h want valid=0 addr=100",
               valid_out, imem_addr);
    end
    tick();
    checks++;
    if (instr_out !== 32'h100 || pc_out !== 32'h104 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL branch_target: got instr=%h pc=%h valid=%b want 100/104/1",
               instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_stalled_redirect();
    run_to_0x10();
    Stall        = 1'b1;
    Branch       = 1'b1;
    BranchTarget = 32'h100;
    tick();
    checks++;
    if (instr_out !== 32'h10 || valid_out !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stalled_branch_ignored: got instr=%h valid=%b req=%b want 10/1/0",
               instr_out, valid_out, imem_req);
    end
    Stall  = 1'b0;
    Branch = 1'b0;
    tick();
    checks++;
    if (instr_out !== 32'h14 || pc_out !== 32'h18 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL stalled_branch_release: got instr=%h pc=%h valid=%b want 14/18/1",
               instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_jump_drop();
    run_to_0x10();
    Jump       = 1'b1;
    JumpTarget = 32'h200;
    imem_ready = 1'b0;
    tick();
    Jump = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL drop_enter: got valid=%b addr=%h req=%b want 0/14/1",
               valid_out, imem_addr, imem_req);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL drop_hold: got valid=%b addr=%h want 0/14", valid_out, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL drop_discard: got valid=%b addr=%h want 0/200", valid_out, imem_addr);
    end
    tick();
    checks++;
    if (instr_out !== 32'h200 || pc_out !== 32'h204 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL jump_target: got instr=%h pc=%h valid=%b want 200/204/1",
               instr_out, pc_out, valid_out);
    end
    Branch        = 1'b1;
    Jump          = 1'b1;
    JumpRegister  = 1'b1;
    BranchTarget  = 32'h500;
    JumpTarget    = 32'h300;
    JumpRegTarget = 32'h400;
    tick();
    Branch = 1'b0; Jump = 1'b0; JumpRegister = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || imem_addr !== 32'h400) begin
      errors++;
      $display("FAIL jr_priority_addr: got valid=%b addr=%h want 0/400", valid_out, imem_addr);
    end
    tick();
    checks++;
    if (instr_out !== 32'h400 || pc_out !== 32'h404 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL jr_priority_instr: got instr=%h pc=%h valid=%b want 400/404/1",
               instr_out, pc_out, valid_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first_addr: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
    end
    tick();
    checks++;
    if (w_instr !== 32'hFFFF_FFFC || w_pc !== 32'h0 || w_valid !== 1'b1 || w_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got instr=%h pc=%h valid=%b addr=%h want fffffffc/0/1/0",
               w_instr, w_pc, w_valid, w_addr);
    end
    tick();
    checks++;
    if (w_instr !== 32'h0 || w_pc !== 32'h4) begin
      errors++;
      $display("FAIL wrap_next: got instr=%h pc=%h want 0/4", w_instr, w_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    tick();
    imem_ready = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0 || imem_addr !== 32'h0 || instr_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got req=%b valid=%b addr=%h instr=%h want 0/0/0/0",
               imem_req, valid_out, imem_addr, instr_out);
    end
    imem_ready = 1'b1;
    tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_skid();
    test_branch();
    test_stalled_redirect();
    test_jump_drop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
